// File: rtl/shared_adder_mult_ctrl.sv
// Shift-and-add multiplier sequencer that time-shares one external WIDTH-bit adder.
// One operand pair per WIDTH+2 cycles: accept, WIDTH add/shift iterations, result handshake.
module shared_adder_mult_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [WIDTH-1:0]     add_op_a,
    output logic [WIDTH-1:0]     add_op_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [CNT_W-1:0]     count;

    // Adder operands come only from registers, so they settle right after each edge.
    always_comb begin
        add_op_a = '0;
        add_op_b = '0;
        if (state == RUN) begin
            add_op_a = acc[2*WIDTH-1:WIDTH];
            add_op_b = acc[0] ? mcand : '0;
        end
    end

    // Gated by rst_n so the source never sees ready while the block is held in reset.
    assign start_ready = rst_n && (state == IDLE);
    assign product     = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        mcand <= a_in;
                        acc   <= {{WIDTH{1'b0}}, b_in};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out lands in the top bit, so the accumulator never overflows.
                    acc   <= {add_cout, add_sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder_mult_ctrl.sv
// Bench for shared_adder_mult_ctrl: directed vectors plus random pairs against an arithmetic model.
module tb_shared_adder_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] product;
    logic        busy;
    logic [7:0]  add_op_a, add_op_b, add_sum;
    logic        add_cout;

    logic        sv4 = 1'b0, rr4 = 1'b0;
    logic        sr4, rv4, busy4, cout4;
    logic [3:0]  a4 = '0, b4 = '0, opa4, opb4, sum4;
    logic [7:0]  p4;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_log[$];
    logic [7:0] opb_hist [8];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_op_a} + {1'b0, add_op_b};
    assign {cout4, sum4}       = {1'b0, opa4} + {1'b0, opb4};

    shared_adder_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a_in(a_in), .b_in(b_in), .res_valid(res_valid), .res_ready(res_ready),
        .product(product), .busy(busy), .add_op_a(add_op_a), .add_op_b(add_op_b),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    shared_adder_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .a_in(a4), .b_in(b4), .res_valid(rv4), .res_ready(rr4),
        .product(p4), .busy(busy4), .add_op_a(opa4), .add_op_b(opb4),
        .add_sum(sum4), .add_cout(cout4)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: phase 0 idle, 1 iterating, 2 holding result; arithmetic is plain multiplication.
    int         phase = 0;
    int         it = 0;
    logic [7:0] ma = '0, mb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0;
            it    <= 0;
        end else begin
            case (phase)
                0: if (start_valid) begin ma <= a_in; mb <= b_in; it <= 0; phase <= 1; end
                1: begin it <= it + 1; if (it == 7) phase <= 2; end
                default: if (res_ready) phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [63:0] exp_opa, exp_opb;
        if (rst_n && start_valid && start_ready) acc_log.push_back(cyc);
        check("start_ready", 64'(start_ready), 64'(rst_n && phase == 0));
        check("busy", 64'(busy), 64'(phase != 0));
        check("res_valid", 64'(res_valid), 64'(phase == 2));
        if (!rst_n) check("reset_product", 64'(product), 64'd0);
        if (phase == 2) check("product", 64'(product), 64'(ma) * 64'(mb));
        if (phase == 1) begin
            exp_opa = (64'(ma) * (64'(mb) & ((64'd1 << it) - 64'd1))) >> it;
            exp_opb = mb[it] ? 64'(ma) : 64'd0;
        end else begin
            exp_opa = 64'd0;
            exp_opb = 64'd0;
        end
        check("add_op_a", 64'(add_op_a), exp_opa);
        check("add_op_b", 64'(add_op_b), exp_opb);
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          input bit rr_noise, output logic [15:0] prod, output int lat);
        bit ok = 0;
        a_in = a;
        b_in = b;
        start_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (start_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("accept_wait", 64'(ok), 64'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        lat = 0;
        while (!res_valid && lat < 50) begin
            if (lat < 8) opb_hist[lat] = add_op_b;
            if (rr_noise) res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        res_ready = 1'b0;
        check("done_wait", 64'(res_valid), 64'd1);
        check("latency", 64'(lat), 64'd8);
        prod = product;
        for (int i = 0; i < stall; i++) begin
            check("hold_product", 64'(product), 64'(prod));
            check("hold_start_ready", 64'(start_ready), 64'd0);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            if (i == 1) begin
                start_valid = 1'b1;
                a_in = 8'h77;
                b_in = 8'h99;
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("release_start_ready", 64'(start_ready), 64'd1);
        check("release_res_valid", 64'(res_valid), 64'd0);
    endtask

    task automatic wait_valid(output logic [15:0] prod);
        int n = 0;
        while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_done_wait", 64'(res_valid), 64'd1);
        prod = product;
    endtask

    initial begin
        logic [15:0] p, p1, p2;
        int lat, base, n;
        bit seen;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_start_ready", 64'(start_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_res_valid", 64'(res_valid), 64'd0);

        // Largest operands: multiplicand added on every iteration.
        run_op(8'hFF, 8'hFF, 0, 1'b0, p, lat);
        check("ffxff_product", 64'(p), 64'h0000FE01);
        for (int i = 0; i < 8; i++) check("ffxff_add_op_b", 64'(opb_hist[i]), 64'hFF);

        run_op(8'h00, 8'hA5, 0, 1'b0, p, lat);
        check("zero_product", 64'(p), 64'h0);

        // Backpressure with a stray start pulse while the result is held.
        run_op(8'h0D, 8'h0B, 5, 1'b0, p, lat);
        check("0dx0b_product", 64'(p), 64'h008F);
        check("0dx0b_iter2_op_b", 64'(opb_hist[2]), 64'h0);
        check("0dx0b_iter0_op_b", 64'(opb_hist[0]), 64'h0D);

        // Asynchronous reset during iteration 3.
        a_in = 8'h55; b_in = 8'h33; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_start_ready", 64'(start_ready), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        check("abort_add_op_a", 64'(add_op_a), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (res_valid) seen = 1; end
        check("no_res_valid_after_abort", 64'(seen), 64'd0);
        run_op(8'h12, 8'h34, 0, 1'b0, p, lat);
        check("12x34_product", 64'(p), 64'h03A8);

        // Back-to-back with start_valid and res_ready held high.
        base = acc_log.size();
        res_ready = 1'b1;
        a_in = 8'd3; b_in = 8'd5; start_valid = 1'b1;
        n = 0;
        while (acc_log.size() <= base && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_first_accept", 64'(acc_log.size() > base), 64'd1);
        a_in = 8'd7; b_in = 8'd9;
        wait_valid(p1);
        n = 0;
        while (acc_log.size() <= base + 1 && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_second_accept", 64'(acc_log.size() > base + 1), 64'd1);
        start_valid = 1'b0;
        wait_valid(p2);
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("b2b_product_1", 64'(p1), 64'h000F);
        check("b2b_product_2", 64'(p2), 64'h003F);
        if (acc_log.size() >= base + 2)
            check("b2b_accept_gap", 64'(acc_log[base + 1] - acc_log[base]), 64'd10);

        // Random pairs with result stalls and res_ready noise during iteration.
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'b1, p, lat);
            check("rand_product", 64'(p), 64'(ra) * 64'(rb));
        end

        // Four-bit instance.
        check("w4_idle_ready", 64'(sr4), 64'd1);
        a4 = 4'hF; b4 = 4'hF; sv4 = 1'b1;
        @(posedge clk); #1;
        sv4 = 1'b0;
        n = 0;
        while (!rv4 && n < 50) begin @(posedge clk); #1; n++; end
        check("w4_latency", 64'(n), 64'd4);
        check("w4_product", 64'(p4), 64'hE1);
        rr4 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0;
        check("w4_release_ready", 64'(sr4), 64'd1);
        check("w4_release_valid", 64'(rv4), 64'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_adder_mult_ctrl.md
Name: shared_adder_mult_ctrl

Overview:
- Sequencing controller for an iterative shift-and-add multiplier.
- Time-shares one external combinational WIDTH-bit adder (the ripple chain built from the team's HA/FA cells) across all partial-product accumulations, instead of a full DADDA reduction tree.
- Accepts operand pairs over a valid/ready handshake, runs WIDTH add/shift iterations, then holds the 2*WIDTH-bit product until the consumer accepts it.
- Serves as the low-area alternative to the parallel DADDA multiplier in the same arithmetic subsystem.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operand pair valid.
- start_ready  output  1  controller can accept operands.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- res_valid  output  1  product valid.
- res_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result register.
- busy  output  1  high in RUN or DONE.
- add_op_a  output  WIDTH  shared adder operand A.
- add_op_b  output  WIDTH  shared adder operand B.
- add_sum  input  WIDTH  shared adder sum; combinational, same cycle.
- add_cout  input  1  shared adder carry-out.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, P (2*WIDTH accumulator) =0, mcand=0, count=0, product=0, res_valid=0, busy=0.
- start_ready=0 while rst_n low.
- Reset asserted mid-RUN or in DONE aborts immediately; the in-flight result is discarded.
- State IDLE: start_ready=1, add_op_a=add_op_b=0.
  - On start_valid&&start_ready at an edge: mcand<=a_in, P<={WIDTH'b0,b_in}, count<=0, go RUN.
- State RUN: start_ready=0, busy=1.
  - Combinational: add_op_a=P[2W-1:W]; add_op_b = P[0] ? mcand : 0.
  - Each edge: P<={add_cout, add_sum, P[W-1:1]}, count<=count+1.
  - When count==WIDTH-1 at the edge, go DONE.
  - Adder operands change only at clock edges; the adder must settle within one cycle.
- State DONE: res_valid=1, busy=1, product=P, add_op_a/b=0, start_ready=0.
  - product and res_valid are held stable while res_ready=0, for any number of cycles.
  - On res_ready=1 at an edge, go IDLE; res_valid drops the next cycle.
- Latency: res_valid rises exactly WIDTH edges after the accepting edge.
  - Back-to-back throughput is one product per WIDTH+2 cycles (accept, WIDTH iterations, DONE handshake).
- Simultaneous events:
  - start_valid while in RUN or DONE is ignored; operands are not captured, and the source must hold them.
  - res_ready in IDLE or RUN has no effect.
  - a_in/b_in changes after the accepting edge do not affect the result.
- Arithmetic: unsigned only.
  - Carry from the top accumulator half shifts into bit 2W-1, so no overflow is possible; max result (2^W-1)^2.
- product always reflects P; it is meaningful only while res_valid=1.

Test Plan:
- WIDTH=8, a=0xFF, b=0xFF: res_valid high exactly 8 edges after the handshake edge; product=0xFE01; add_op_b=0xFF on every RUN cycle.
- a=0x00, b=0xA5 -> product=0x0000. a=0x0D, b=0x0B -> product=0x008F; add_op_b=0 on iteration 2 (b bit2=0).
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> product constant, start_ready=0, a start_valid pulse ignored; release -> IDLE next cycle, start_ready=1.
- Reset: assert rst_n=0 mid-cycle during iteration 3 -> outputs clear immediately, no res_valid. Then a=0x12, b=0x34 -> product=0x03A8.
- Back-to-back: start_valid held high with pairs (3,5),(7,9) -> products 0x000F then 0x003F; second accept occurs 10 cycles after the first.
- WIDTH=4: 0xF*0xF -> 0xE1. Then 1000 random pairs at WIDTH=8 against a behavioural multiply model with random res_ready stalls -> zero mismatches.
